core_test_harness: RTL and testbench

Synthesisable program-load and run controller that replaces ad-hoc bench tasks for poking instruction/data memory and stepping the core. It accepts a command stream to write the instruction and data memories while holding the core in reset. It then releases the core for a bounded run, stopping on a halt PC or when the cycle budget is exhausted, and reports the cycle count and the stop cause. It sits between a host or bench driver and the RISC-V core's memories and reset.

---
 rtl/core_test_harness_pkg.sv | 17 +
 rtl/harness_trace_fifo.sv | 65 ++++++
 rtl/core_test_harness.sv | 247 ++++++++++++++++++++++++
 tb/tb_core_test_harness.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_test_harness_pkg.sv
// Shared definitions for the program-load / run controller: command
// encodings and the controller state enum.
package core_test_harness_pkg;

    localparam logic [1:0] OP_WR_IMEM = 2'b00;
    localparam logic [1:0] OP_WR_DMEM = 2'b01;
    localparam logic [1:0] OP_RUN     = 2'b10;
    localparam logic [1:0] OP_ABORT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/harness_trace_fifo.sv
// Small synchronous FIFO for the PC trace. Pushes while full are dropped
// (the caller tracks overflow); flush empties it in one cycle.
// DEPTH must be a power of two and at least 2.
module harness_trace_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    // Read data is forced to zero when empty so the stream idles at 0.
    assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values; flush wins over any push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/core_test_harness.sv
// Program-load and run controller: writes instruction/data memories while
// the core is held in reset, then runs it until a halt PC, the cycle budget
// or an ABORT, reporting cycle count and stop cause.
// Optional PC trace stream enabled by defining CORE_TEST_HARNESS_TRACE_EN.
module core_test_harness
    import core_test_harness_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int IMEM_AW     = 10,
    parameter int DMEM_AW     = 10,
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [XLEN-1:0]    cmd_addr,
    input  logic [XLEN-1:0]    cmd_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [XLEN-1:0]    imem_wdata,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    output logic               core_rst,
    input  logic [XLEN-1:0]    core_pc,
    output logic               done,
    output logic               halted_ok,
    output logic               addr_err,
    output logic [CNT_W-1:0]   cycles,
    output logic               trace_valid,
    input  logic               trace_ready,
    output logic [XLEN-1:0]    trace_pc,
    output logic               trace_ovf
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic               core_rst_q, core_rst_d;
    logic               done_q, done_d;
    logic               halted_ok_q, halted_ok_d;
    logic               addr_err_q, addr_err_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic [XLEN-1:0]    halt_pc_q, halt_pc_d;
    logic [CNT_W-1:0]   budget_q, budget_d;
    logic               imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [XLEN-1:0]    imem_wdata_q, imem_wdata_d;
    logic               dmem_we_q, dmem_we_d;
    logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0]    dmem_wdata_q, dmem_wdata_d;

    logic               cmd_fire;
    logic               imem_oob;
    logic               dmem_oob;
    logic [CNT_W-1:0]   cycles_inc;
    logic               pc_hit;
    logic               budget_hit;

    // Handshake: a command transfers on cmd_valid && cmd_ready. Ready is high
    // in IDLE/DONE, only for ABORT during RUN, and never during WRITE.
    always_comb begin
        case (state_q)
            ST_IDLE, ST_DONE: cmd_ready = 1'b1;
            ST_RUN:           cmd_ready = (cmd_op == OP_ABORT);
            default:          cmd_ready = 1'b0;
        endcase
    end

    assign cmd_fire   = cmd_valid && cmd_ready;
    assign imem_oob   = |cmd_addr[XLEN-1:IMEM_AW+2];
    assign dmem_oob   = |cmd_addr[XLEN-1:DMEM_AW+2];
    assign cycles_inc = cycles_q + CNT_ONE;
    assign pc_hit     = (core_pc == halt_pc_q);
    assign budget_hit = (cycles_inc == budget_q);

    // Controller next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        core_rst_d   = core_rst_q;
        done_d       = done_q;
        halted_ok_d  = halted_ok_q;
        addr_err_d   = addr_err_q;
        cycles_d     = cycles_q;
        halt_pc_d    = halt_pc_q;
        budget_d     = budget_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_we_d    = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cmd_fire) begin
                    // Any accepted command clears the previous run's status.
                    done_d      = 1'b0;
                    halted_ok_d = 1'b0;
                    cycles_d    = '0;
                    state_d     = ST_IDLE;
                    case (cmd_op)
                        OP_WR_IMEM: begin
                            state_d = ST_WRITE;
                            if (imem_oob) begin
                                addr_err_d = 1'b1;
                            end else begin
                                imem_we_d    = 1'b1;
                                imem_addr_d  = cmd_addr[IMEM_AW+1:2];
                                imem_wdata_d = cmd_data;
                            end
                        end
                        OP_WR_DMEM: begin
                            state_d = ST_WRITE;
                            if (dmem_oob) begin
                                addr_err_d = 1'b1;
                            end else begin
                                dmem_we_d    = 1'b1;
                                dmem_addr_d  = cmd_addr[DMEM_AW+1:2];
                                dmem_wdata_d = cmd_data;
                            end
                        end
                        OP_RUN: begin
                            halt_pc_d = cmd_addr;
                            budget_d  = cmd_data[CNT_W-1:0];
                            if (cmd_data[CNT_W-1:0] == '0) begin
                                // Zero budget: finish without releasing the core.
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d    = ST_RUN;
                                core_rst_d = 1'b0;
                            end
                        end
                        default: ; // ABORT outside a run only clears status
                    endcase
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_RUN: begin
                // The current cycle counts even when it is the stopping one.
                if (!core_rst_q) cycles_d = (&cycles_q) ? cycles_q : cycles_inc;
                if (cmd_fire || pc_hit || budget_hit) begin
                    state_d     = ST_DONE;
                    core_rst_d  = 1'b1;
                    done_d      = 1'b1;
                    halted_ok_d = !cmd_fire && pc_hit;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            halted_ok_q  <= 1'b0;
            addr_err_q   <= 1'b0;
            cycles_q     <= '0;
            halt_pc_q    <= '0;
            budget_q     <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            halted_ok_q  <= halted_ok_d;
            addr_err_q   <= addr_err_d;
            cycles_q     <= cycles_d;
            halt_pc_q    <= halt_pc_d;
            budget_q     <= budget_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign halted_ok  = halted_ok_q;
    assign addr_err   = addr_err_q;
    assign cycles     = cycles_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;

`ifdef CORE_TEST_HARNESS_TRACE_EN
    logic trace_push;
    logic trace_flush;
    logic trace_full;
    logic trace_empty;
    logic trace_ovf_q, trace_ovf_d;

    assign trace_push  = (state_q == ST_RUN) && !core_rst_q;
    assign trace_flush = cmd_fire && (cmd_op == OP_RUN) && (state_q != ST_RUN);
    assign trace_valid = !trace_empty;

    harness_trace_fifo #(
        .WIDTH(XLEN),
        .DEPTH(TRACE_DEPTH)
    ) u_trace_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(trace_flush),
        .push (trace_push),
        .din  (core_pc),
        .pop  (trace_valid && trace_ready),
        .dout (trace_pc),
        .empty(trace_empty),
        .full (trace_full)
    );

    // Overflow is sticky until reset; a RUN flush does not clear it.
    always_comb trace_ovf_d = trace_ovf_q | (trace_push & trace_full);

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) trace_ovf_q <= 1'b0;
        else     trace_ovf_q <= trace_ovf_d;
    end

    assign trace_ovf = trace_ovf_q;
`else
    // Trace disabled: stream idles and its inputs/depth are intentionally unused.
    logic unused_trace;
    assign unused_trace = trace_ready | (TRACE_DEPTH < 2);
    assign trace_valid  = 1'b0;
    assign trace_pc     = '0;
    assign trace_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_core_test_harness.sv
// Bench for core_test_harness: table-driven command vectors checked through
// an expected-result queue, plus hand sequences for zero budget, ABORT,
// status clearing, the optional trace stream and reset during a run.
module tb_core_test_harness;
    import core_test_harness_pkg::*;

    localparam int XLEN        = 32;
    localparam int IMEM_AW     = 10;
    localparam int DMEM_AW     = 10;
    localparam int CNT_W       = 32;
    localparam int TRACE_DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'b00;
    logic [XLEN-1:0]    cmd_addr = '0;
    logic [XLEN-1:0]    cmd_data = '0;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [XLEN-1:0]    imem_wdata;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [XLEN-1:0]    dmem_wdata;
    logic               core_rst;
    logic [XLEN-1:0]    core_pc = '0;
    logic               done;
    logic               halted_ok;
    logic               addr_err;
    logic [CNT_W-1:0]   cycles;
    logic               trace_valid;
    logic               trace_ready = 1'b0;
    logic [XLEN-1:0]    trace_pc;
    logic               trace_ovf;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    core_test_harness #(
        .XLEN(XLEN), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW),
        .CNT_W(CNT_W), .TRACE_DEPTH(TRACE_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .core_rst(core_rst), .core_pc(core_pc),
        .done(done), .halted_ok(halted_ok), .addr_err(addr_err), .cycles(cycles),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_ovf(trace_ovf)
    );

    // Core stand-in: PC sits at 0 in reset and advances by 4 per running cycle.
    always @(posedge clk) core_pc <= (core_rst !== 1'b0) ? '0 : core_pc + 32'd4;

    // ---------------- scoreboard ----------------
    int              n_checks = 0;
    int              n_errors = 0;
    logic [63:0]     exp_q[$];
    logic [XLEN-1:0] trace_exp_q[$];
    bit              exp_ovf = 1'b0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        e_imem_we;
        logic        e_dmem_we;
        logic [9:0]  e_waddr;
        logic        e_err;
        logic        e_halted;
        logic [31:0] e_cycles;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_write(input logic wi, input logic wd,
                                               input logic [9:0] a, input logic [31:0] d,
                                               input logic err);
        return {19'd0, wi, wd, a, d, err};
    endfunction

    function automatic logic [63:0] pack_run(input logic dn, input logic h,
                                             input logic [31:0] c, input logic cr);
        return {29'd0, dn, h, c, cr};
    endfunction

    function automatic logic [63:0] observe_write();
        logic [9:0]  a;
        logic [31:0] d;
        a = imem_we ? imem_addr : (dmem_we ? dmem_addr : 10'd0);
        d = imem_we ? imem_wdata : (dmem_we ? dmem_wdata : 32'd0);
        return pack_write(imem_we, dmem_we, a, d, addr_err);
    endfunction

    task automatic add_vec(input string name, input logic [1:0] op,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic ewi, input logic ewd, input logic [9:0] ewa,
                           input logic eerr, input logic ehalt, input logic [31:0] ecyc);
        vec_t v;
        v.name = name; v.op = op; v.addr = addr; v.data = data;
        v.e_imem_we = ewi; v.e_dmem_we = ewd; v.e_waddr = ewa; v.e_err = eerr;
        v.e_halted = ehalt; v.e_cycles = ecyc;
        vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        exp_ovf = 1'b0;
        trace_exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {core_rst, done, halted_ok, addr_err, imem_we, dmem_we,
                              trace_valid, trace_ovf, cmd_ready}, 9'b1_0000_0001);
        check("reset_cycles", cycles, 0);
        check("reset_wdata", {imem_wdata, dmem_wdata}, 0);
        check("reset_addr", {imem_addr, dmem_addr, trace_pc}, 0);
        rst = 1'b0;
    endtask

    // Returns #1 after the edge on which the command was accepted.
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        if (op == OP_RUN) trace_exp_q.delete();
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
        #1;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++; n_errors++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, n);
        end else begin
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    // Waits for done, counting core cycles and modelling the trace FIFO.
    task automatic run_wait(input string name, input int bound, output int core_cnt);
        int n;
        n = 0;
        core_cnt = 0;
        while (done !== 1'b1 && n < bound) begin
            if (core_rst === 1'b0) begin
                core_cnt++;
                if (trace_exp_q.size() < TRACE_DEPTH) trace_exp_q.push_back(core_pc);
                else exp_ovf = 1'b1;
            end
            @(posedge clk); #1; n++;
        end
        if (done !== 1'b1) begin
            n_checks++; n_errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, expected 1", name, done, n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // ---------------- test ----------------
    initial begin
        int          core_cnt;
        int          drained;
        int          n;
        bit          released;
        logic [31:0] rnd;

        rnd = $urandom_range(32'h7FFF_FFFF, 0);
        add_vec("wr_imem_8",   OP_WR_IMEM, 32'h8,         32'h00500093, 1, 0, 10'd2,   0, 0, 0);
        add_vec("wr_imem_top", OP_WR_IMEM, 32'hFFF,       32'hDEADBEEF, 1, 0, 10'h3FF, 0, 0, 0);
        add_vec("wr_dmem_4",   OP_WR_DMEM, 32'h4,         32'h12345678, 0, 1, 10'd1,   0, 0, 0);
        add_vec("wr_dmem_7",   OP_WR_DMEM, 32'h7,         32'hA5A5A5A5, 0, 1, 10'd1,   0, 0, 0);
        add_vec("wr_dmem_oob", OP_WR_DMEM, 32'h1000,      32'hCAFEF00D, 0, 0, 10'd0,   1, 0, 0);
        add_vec("wr_imem_oob", OP_WR_IMEM, 32'h8000_0004, 32'h1,        0, 0, 10'd0,   1, 0, 0);
        add_vec("wr_imem_10",  OP_WR_IMEM, 32'h10,        rnd,          1, 0, 10'd4,   1, 0, 0);
        add_vec("run_halt_c",  OP_RUN,     32'hC,         32'd100,      0, 0, 10'd0,   0, 1, 4);
        add_vec("run_budget5", OP_RUN,     32'hFFF0,      32'd5,        0, 0, 10'd0,   0, 0, 5);
        add_vec("run_budget2", OP_RUN,     32'h8,         32'd2,        0, 0, 10'd0,   0, 0, 2);
        add_vec("run_tie",     OP_RUN,     32'h0,         32'd1,        0, 0, 10'd0,   0, 1, 1);

        do_reset();

        foreach (vecs[i]) begin
            if (vecs[i].op == OP_RUN) begin
                exp_q.push_back(pack_run(1'b1, vecs[i].e_halted, vecs[i].e_cycles, 1'b1));
                send_cmd(vecs[i].op, vecs[i].addr, vecs[i].data);
                run_wait(vecs[i].name, 200, core_cnt);
                check({vecs[i].name, "_core_cycles"}, core_cnt, vecs[i].e_cycles);
                check(vecs[i].name, pack_run(done, halted_ok, cycles, core_rst), exp_q.pop_front());
            end else begin
                exp_q.push_back(pack_write(vecs[i].e_imem_we, vecs[i].e_dmem_we,
                    (vecs[i].e_imem_we | vecs[i].e_dmem_we) ? vecs[i].e_waddr : 10'd0,
                    (vecs[i].e_imem_we | vecs[i].e_dmem_we) ? vecs[i].data : 32'd0,
                    vecs[i].e_err));
                send_cmd(vecs[i].op, vecs[i].addr, vecs[i].data);
                check({vecs[i].name, "_ready_low"}, cmd_ready, 0);
                check(vecs[i].name, observe_write(), exp_q.pop_front());
                @(posedge clk); #1;
                check({vecs[i].name, "_pulse_end"}, {imem_we, dmem_we, cmd_ready}, 3'b001);
            end
        end

        // ABORT in DONE clears the previous halted status.
        send_cmd(OP_ABORT, 32'h0, 32'h0);
        check("abort_in_done", pack_run(done, halted_ok, cycles, core_rst), pack_run(0, 0, 0, 1));
        check("abort_in_done_ready", cmd_ready, 1);

        // ABORT in IDLE does nothing.
        send_cmd(OP_ABORT, 32'h0, 32'h0);
        check("abort_in_idle", {done, core_rst, cmd_ready, imem_we, dmem_we}, 5'b01100);

        // Zero budget: done next cycle, core never leaves reset.
        send_cmd(OP_RUN, 32'h0, 32'h0);
        check("budget0", pack_run(done, halted_ok, cycles, core_rst), pack_run(1, 0, 0, 1));
        released = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (core_rst !== 1'b1 || done !== 1'b1) released = 1'b1;
        end
        check("budget0_core_held", released, 0);

        // A write accepted in DONE clears status and still writes.
        send_cmd(OP_RUN, 32'h4, 32'd10);
        run_wait("run_halt_4", 50, core_cnt);
        check("run_halt_4", pack_run(done, halted_ok, cycles, core_rst), pack_run(1, 1, 2, 1));
        send_cmd(OP_WR_DMEM, 32'h8, 32'h55);
        check("wr_in_done_clears", pack_run(done, halted_ok, cycles, core_rst), pack_run(0, 0, 0, 1));
        check("wr_in_done_write", {dmem_we, dmem_addr, dmem_wdata}, {1'b1, 10'd2, 32'h55});
        @(posedge clk); #1;

        // ABORT three core cycles into a run; a write is refused mid-run.
        send_cmd(OP_RUN, 32'hFFF0, 32'd100);
        @(posedge clk); #1;
        cmd_op = OP_WR_IMEM; cmd_addr = 32'h0; cmd_data = 32'h0; cmd_valid = 1'b1;
        #1;
        check("run_blocks_write", cmd_ready, 0);
        @(posedge clk); #1;
        check("run_write_ignored", {imem_we, done, core_rst}, 3'b000);
        cmd_op = OP_ABORT;
        #1;
        check("run_abort_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("abort_run", pack_run(done, halted_ok, cycles, core_rst), pack_run(1, 0, 3, 1));

        // Trace: 6-cycle run with the stream stalled.
        do_reset();
        trace_ready = 1'b0;
        send_cmd(OP_RUN, 32'hFFF0, 32'd6);
        run_wait("trace_run", 50, core_cnt);
        check("trace_run", pack_run(done, halted_ok, cycles, core_rst), pack_run(1, 0, 6, 1));
`ifdef CORE_TEST_HARNESS_TRACE_EN
        check("trace_ovf_set", trace_ovf, exp_ovf);
        trace_ready = 1'b1;
        drained = 0;
        n = 0;
        #1;
        while (trace_valid === 1'b1 && n < 2 * TRACE_DEPTH) begin
            if (trace_exp_q.size() == 0) begin
                check("trace_extra", trace_valid, 0);
            end else begin
                check($sformatf("trace_pc_%0d", drained), trace_pc, trace_exp_q.pop_front());
            end
            drained++;
            @(posedge clk); #1; n++;
        end
        trace_ready = 1'b0;
        check("trace_count", drained, TRACE_DEPTH);
        check("trace_drained", trace_valid, 0);
`else
        check("trace_off", {trace_valid, trace_ovf, trace_pc}, 0);
`endif

        // Reset in the middle of a run: no done, core back in reset.
        send_cmd(OP_RUN, 32'hFFF0, 32'd100);
        repeat (2) begin @(posedge clk); #1; end
`ifdef CORE_TEST_HARNESS_TRACE_EN
        check("trace_ovf_sticky", trace_ovf, 1);
`endif
        check("midrun_running", {core_rst, done}, 2'b00);
        do_reset();
        released = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || core_rst !== 1'b1) released = 1'b1;
        end
        check("midrun_reset_quiet", released, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
